// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: loader > dbus > ibus fixed priority with ibus starvation
// promotion, and one-cycle-late read data returned to the requester that issued the read.
module ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_req_i,
  input  logic [31:0]       ld_addr_i,
  input  logic [3:0]        ld_we_i,
  input  logic [31:0]       ld_wdata_i,
  input  logic              d_req_i,
  input  logic [31:0]       d_addr_i,
  input  logic [3:0]        d_we_i,
  input  logic [31:0]       d_wdata_i,
  input  logic              i_req_i,
  input  logic [31:0]       i_addr_i,
  output logic              ld_gnt_o,
  output logic              d_gnt_o,
  output logic              i_gnt_o,
  output logic              d_rvalid_o,
  output logic              i_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic [31:0]       i_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Handshake: a requester holds req (and its address/data) until it sees gnt in the
  // same cycle; a granted read returns exactly one rvalid pulse on the following cycle.

  owner_e     r_owner, w_owner_nxt;
  logic [3:0] r_wait_cnt, w_wait_nxt;
  logic       w_promote;

  assign w_promote = i_req_i && (r_wait_cnt == MAX_WAIT_C);

  assign ld_gnt_o = ld_req_i;
  assign d_gnt_o  = !ld_req_i && d_req_i && !w_promote;
  assign i_gnt_o  = !ld_req_i && i_req_i && (!d_req_i || w_promote);

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = '0;
    ram_wdata_o = '0;
    if (ld_gnt_o) begin
      ram_addr_o  = ld_addr_i[ADDR_W+1:2];
      ram_we_o    = ld_we_i;
      ram_wdata_o = ld_wdata_i;
    end else if (d_gnt_o) begin
      ram_addr_o  = d_addr_i[ADDR_W+1:2];
      ram_we_o    = d_we_i;
      ram_wdata_o = d_wdata_i;
    end else if (i_gnt_o) begin
      ram_addr_o  = i_addr_i[ADDR_W+1:2];
    end
  end

  // Loader reads and all writes leave the owner tag empty, so no rvalid follows them.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (d_gnt_o && (d_we_i == 4'd0)) begin
      w_owner_nxt = OWN_D;
    end else if (i_gnt_o) begin
      w_owner_nxt = OWN_I;
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!i_req_i || i_gnt_o) begin
      w_wait_nxt = 4'd0;
    end else if (r_wait_cnt != MAX_WAIT_C) begin
      w_wait_nxt = r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  assign d_rvalid_o = (r_owner == OWN_D);
  assign i_rvalid_o = (r_owner == OWN_I);
  assign d_rdata_o  = d_rvalid_o ? ram_rdata_i : 32'd0;
  assign i_rdata_o  = i_rvalid_o ? ram_rdata_i : 32'd0;

  // Aliased upper bits and byte-offset bits play no part in the word address.
  logic w_unused;
  assign w_unused = ^{ld_addr_i[31:ADDR_W+2], ld_addr_i[1:0],
                      d_addr_i[31:ADDR_W+2],  d_addr_i[1:0],
                      i_addr_i[31:ADDR_W+2],  i_addr_i[1:0]};

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port main RAM between three requesters: the UART boot loader, the CPU data bus and the CPU instruction bus. It sits inside `main` between the core/loader and the RAM array. It issues one RAM access per cycle and routes the one-cycle-late read data back to the requester that issued it. Fixed priority is loader > dbus > ibus, with a starvation counter that promotes ibus over dbus.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width (2^14 words = 64 KiB).
- `MAX_WAIT`, 4: consecutive stalled ibus cycles before ibus outranks dbus; must be 1..15.

Ports:
- `clk_i`  in  1  system clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `ld_req_i`, `d_req_i`, `i_req_i`  in  1 each  access requests; each is held until granted.
- `ld_addr_i`, `d_addr_i`, `i_addr_i`  in  32 each  byte addresses.
- `ld_we_i`, `d_we_i`  in  4 each  byte write enables; 0 means read. ibus is read-only.
- `ld_wdata_i`, `d_wdata_i`  in  32 each  write data.
- `ld_gnt_o`, `d_gnt_o`, `i_gnt_o`  out  1 each  access accepted this cycle (combinational).
- `d_rvalid_o`, `i_rvalid_o`  out  1 each  read data valid (registered).
- `d_rdata_o`, `i_rdata_o`  out  32 each  read data; equals `ram_rdata_i` while the matching rvalid is high.
- `ram_addr_o`  out  ADDR_W  word address, taken from `addr[ADDR_W+1:2]` of the winner.
- `ram_we_o`  out  4  byte enables of the winner; 0 when idle or on a read.
- `ram_wdata_o`  out  32  write data of the winner.
- `ram_rdata_i`  in  32  RAM read data, valid one cycle after the address.

## Operation
- Each cycle, at most one gnt is high. It goes to the highest-priority requester whose req is high.
- Base order: loader, then dbus, then ibus.
- Promotion: when `wait_cnt == MAX_WAIT` and `i_req_i` is high, ibus beats dbus. It never beats the loader.
- The winner's address, we and wdata drive the RAM port combinationally in the grant cycle.
- With no request, `ram_we_o` is 0 and `ram_addr_o` is don't-care.
- A granted read has `we == 0`. Reads are recorded in a registered owner tag: none, dbus or ibus.
- The next cycle, the owner's rvalid is high. Its rdata is `ram_rdata_i`.
- Loader reads are not returned: the loader is write-only, so a loader read is granted and its data discarded.
- Writes complete in the grant cycle and produce no rvalid.
- Address bits above `ADDR_W+1` are ignored (aliasing). Address bits [1:0] are ignored; byte selection is by we only.
- `wait_cnt` (4-bit) updates as follows:
  - Increments each cycle `i_req_i` is high and `i_gnt_o` is low.
  - Saturates at `MAX_WAIT`.
  - Clears on `i_gnt_o`, or when `i_req_i` is low.
- Requesters may issue back-to-back. A new grant in cycle N+1 coexists with rvalid for the cycle-N read.

## Timing
- Reset (`rst_ni` low, asynchronous): owner tag = none, `wait_cnt` = 0.
  - Both rvalid outputs are 0 immediately.
  - gnt outputs follow the req inputs combinationally; the RAM port is 0 if no req.
- Grant latency: 0 cycles. Read-data latency: 1 cycle after gnt. Throughput: 1 access per cycle.
- Simultaneous `d_req_i` and `i_req_i` with `wait_cnt < MAX_WAIT`: dbus wins.
  - The ibus stall cycle increments `wait_cnt`.
- At `MAX_WAIT`, ibus wins exactly once, then `wait_cnt` clears and dbus regains priority.
  - A continuously requesting dbus therefore yields one slot in every `MAX_WAIT+1` to ibus.
- Reset asserted while a read is in flight: the rvalid for that read is suppressed. Requesters must reissue.
- An rvalid pulse lasts exactly one cycle. There is no backpressure on read data.

## Test plan
- Reset, then `d_req` read of address 0x100 with RAM word 64 = 0xDEADBEEF:
  - `d_gnt` the same cycle, `ram_addr_o` = 64.
  - The next cycle, `d_rvalid` = 1 and `d_rdata` = 0xDEADBEEF; `i_rvalid` = 0.
- All three reqs held; loader writes 0x12345678 with we = 0xF to 0x0:
  - Only `ld_gnt` is high, `ram_we_o` = 0xF, `ram_wdata_o` = 0x12345678.
  - No rvalid follows.
- dbus and ibus both held continuously with `MAX_WAIT` = 4:
  - Grant sequence is d,d,d,d,i,d,d,d,d,i.
  - Each ibus grant is followed by `i_rvalid` one cycle later.
- Back-to-back: dbus read in cycle N, ibus read in cycle N+1:
  - `d_rvalid` in N+1 and `i_rvalid` in N+2, each carrying its own word.
- dbus write with we = 0x3 to address 0x40010:
  - Aliases to word `0x10004 & 0x3FFF` = 4; `ram_we_o` = 0x3.
  - No rvalid.
- Assert `rst_ni` low mid-cycle right after a dbus read grant:
  - `d_rvalid` stays 0; after release, `wait_cnt` = 0 and the arbiter is idle.
